// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: pipeline writeback, long-unit handshake, RF write port, status.
// slave = arbiter view, master = driver view (pipeline/long-unit/RF side).
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb_en;
  logic              wb_sys_en;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_W-1:0]  lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              rf_we;
  logic              rf_sys_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pipe_stall;
  logic [REG_W-1:0]  pend_q;
  logic              pend_hit;
  logic [CNT_W-1:0]  fifo_count;
  logic              proto_err;

  modport slave (
    input  wb_en, wb_sys_en, wb_rd, wb_data, lu_valid, lu_rd, lu_data, pend_q,
    output lu_ready, rf_we, rf_sys_we, rf_waddr, rf_wdata, pipe_stall, pend_hit,
    output fifo_count, proto_err
  );

  modport master (
    output wb_en, wb_sys_en, wb_rd, wb_data, lu_valid, lu_rd, lu_data, pend_q,
    input  lu_ready, rf_we, rf_sys_we, rf_waddr, rf_wdata, pipe_stall, pend_hit,
    input  fifo_count, proto_err
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// RF write-port arbiter: pipeline has priority (0-cycle path), long-unit results queue in a FIFO
// drained on idle slots or by a one-cycle forced stall; lu_ready=!full. WB_FWD_EN: idle-slot bypass.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, PIPE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [REG_W-1:0]  rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              perr_q, perr_d;

  logic              full, fwd, push, pop, lu_ready, hit;
  logic              we, sys_we;
  logic [REG_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    fwd      = 1'b0;
`ifdef WB_FWD_EN
    fwd      = (state_q == IDLE) && !bus.wb_en && bus.lu_valid;
`endif
    lu_ready = !reset && !full;
    push     = lu_ready && bus.lu_valid && !fwd;
    pop      = 1'b0;
    we       = bus.wb_en;
    sys_we   = bus.wb_sys_en;
    waddr    = bus.wb_rd;
    wdata    = bus.wb_data;
    starve_d = '0;
    state_d  = state_q;

    case (state_q)
      IDLE: begin
        if (fwd) begin
          we     = 1'b1;
          sys_we = 1'b0;
          waddr  = bus.lu_rd;
          wdata  = bus.lu_data;
        end
      end
      PIPE: begin
        if (!bus.wb_en) begin
          pop    = 1'b1;
          we     = 1'b1;
          sys_we = 1'b0;
          waddr  = rd_mem_q[rd_ptr_q];
          wdata  = data_mem_q[rd_ptr_q];
        end
      end
      default: begin
        // Forced drain: the pipeline is stalled, so its request is dropped.
        pop    = 1'b1;
        we     = 1'b1;
        sys_we = 1'b0;
        waddr  = rd_mem_q[rd_ptr_q];
        wdata  = data_mem_q[rd_ptr_q];
      end
    endcase

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      IDLE:    state_d = push ? PIPE : IDLE;
      PIPE: begin
        if (bus.wb_en) begin
          starve_d = starve_q + SC_W'(1);
          state_d  = (starve_q == SC_W'(STARVE_MAX - 1)) ? DRAIN : PIPE;
        end else begin
          state_d  = (count_d == '0) ? IDLE : PIPE;
        end
      end
      default: state_d = (count_d == '0) ? IDLE : PIPE;
    endcase

    stall_d = (state_d == DRAIN);
    perr_d  = perr_q || (bus.wb_en && stall_q);

    if (reset) begin
      we     = 1'b0;
      sys_we = 1'b0;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) && (rd_mem_q[rd_ptr_q + PTR_W'(k)] == bus.pend_q)
          && (bus.pend_q != '0))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      perr_q   <= perr_d;
      if (push) begin
        rd_mem_q[wr_ptr_q]   <= bus.lu_rd;
        data_mem_q[wr_ptr_q] <= bus.lu_data;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.lu_ready   = lu_ready;
  assign bus.rf_we      = we;
  assign bus.rf_sys_we  = sys_we;
  assign bus.rf_waddr   = waddr;
  assign bus.rf_wdata   = wdata;
  assign bus.pipe_stall = stall_q;
  assign bus.pend_hit   = hit;
  assign bus.fifo_count = count_q;
  assign bus.proto_err  = perr_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: scenario tasks with a queue model of the long-unit FIFO.
module tb_wb_port_arbiter;
  localparam int DATA_W = 32, REG_W = 5, DEPTH = 4, STARVE_MAX = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {logic [REG_W-1:0] rd; logic [DATA_W-1:0] data;} ent_t;
  ent_t sb[$];
  int total  = 0;
  int passed = 0;

  task automatic idle_inputs();
    bus.wb_en = 1'b0; bus.wb_sys_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_data = '0; bus.pend_q = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // From IDLE: queue one entry, then hold wb_en=1 for STARVE_MAX cycles; returns at the drain cycle.
  task automatic queue_and_starve(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    ent_t e;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2;
    bus.lu_valid = 1'b1; bus.lu_rd = rd; bus.lu_data = d;
    e.rd = rd; e.data = d; sb.push_back(e);
    next_cycle();
    bus.lu_valid = 1'b0;
    repeat (STARVE_MAX) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.wb_en = 1'b1; bus.wb_sys_en = 1'b1; bus.lu_valid = 1'b1; bus.pend_q = 5'd3;
    next_cycle();
    @(negedge clk);
    total++; if (bus.rf_we !== 1'b0) $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); else passed++;
    total++; if (bus.rf_sys_we !== 1'b0) $display("FAIL reset_rf_sys_we got %b exp 0", bus.rf_sys_we); else passed++;
    total++; if (bus.lu_ready !== 1'b0) $display("FAIL reset_lu_ready got %b exp 0", bus.lu_ready); else passed++;
    total++; if (bus.fifo_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", bus.fifo_count); else passed++;
    total++; if (bus.pipe_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.pipe_stall); else passed++;
    total++; if (bus.proto_err !== 1'b0) $display("FAIL reset_perr got %b exp 0", bus.proto_err); else passed++;
    total++; if (bus.pend_hit !== 1'b0) $display("FAIL reset_pend got %b exp 0", bus.pend_hit); else passed++;
    idle_inputs();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_pipe_write();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h11;
    @(negedge clk);
    total++; if (bus.rf_we !== 1'b1) $display("FAIL pipe_we got %b exp 1", bus.rf_we); else passed++;
    total++; if (bus.rf_waddr !== 5'd3) $display("FAIL pipe_waddr got %0d exp 3", bus.rf_waddr); else passed++;
    total++; if (bus.rf_wdata !== 32'h11) $display("FAIL pipe_wdata got %h exp 11", bus.rf_wdata); else passed++;
    total++; if (bus.fifo_count !== 3'd0) $display("FAIL pipe_count got %0d exp 0", bus.fifo_count); else passed++;
    next_cycle();
    bus.wb_sys_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h22;
    @(negedge clk);
    total++; if (bus.rf_sys_we !== 1'b1) $display("FAIL pipe_sys_we got %b exp 1", bus.rf_sys_we); else passed++;
    total++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h22)
      $display("FAIL pipe_r0 got %0d/%h exp 0/22", bus.rf_waddr, bus.rf_wdata); else passed++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_lu_path();
    ent_t e;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd5; bus.lu_data = 32'hAB;
    @(negedge clk);
    total++; if (bus.lu_ready !== 1'b1) $display("FAIL lu_ready got %b exp 1", bus.lu_ready); else passed++;
`ifdef WB_FWD_EN
    total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hAB)
      $display("FAIL lu_fwd got %b/%0d/%h exp 1/5/ab", bus.rf_we, bus.rf_waddr, bus.rf_wdata); else passed++;
    next_cycle();
    bus.lu_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.fifo_count !== 3'd0) $display("FAIL lu_fwd_count got %0d exp 0", bus.fifo_count); else passed++;
`else
    e.rd = 5'd5; e.data = 32'hAB; sb.push_back(e);
    total++; if (bus.rf_we !== 1'b0) $display("FAIL lu_no_fwd_we got %b exp 0", bus.rf_we); else passed++;
    next_cycle();
    bus.lu_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.fifo_count !== 3'd1) $display("FAIL lu_count got %0d exp 1", bus.fifo_count); else passed++;
    e = sb.pop_front();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_sys_we !== 1'b0 || bus.rf_waddr !== e.rd || bus.rf_wdata !== e.data)
      $display("FAIL lu_pop got %b/%b/%0d/%h exp 1/0/%0d/%h", bus.rf_we, bus.rf_sys_we, bus.rf_waddr,
               bus.rf_wdata, e.rd, e.data); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (bus.fifo_count !== 3'd0) $display("FAIL lu_count_after got %0d exp 0", bus.fifo_count); else passed++;
`endif
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_fill_and_drain();
    ent_t e;
    logic rdy_exp;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.lu_valid = 1'b1; bus.lu_rd = REG_W'(10 + i); bus.lu_data = $urandom;
      @(negedge clk);
      rdy_exp = (sb.size() < DEPTH);
      total++; if (bus.lu_ready !== rdy_exp) $display("FAIL fill_ready[%0d] got %b exp %b", i, bus.lu_ready, rdy_exp); else passed++;
      total++; if (bus.fifo_count !== 3'(sb.size())) $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.fifo_count, sb.size()); else passed++;
      total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1) $display("FAIL fill_pipe[%0d] got %b/%0d exp 1/1", i, bus.rf_we, bus.rf_waddr); else passed++;
      if (rdy_exp) begin e.rd = bus.lu_rd; e.data = bus.lu_data; sb.push_back(e); end
      next_cycle();
    end
    bus.wb_en = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.lu_valid = (i == 1); bus.lu_rd = 5'd20; bus.lu_data = 32'hC0DE;
      @(negedge clk);
      rdy_exp = (sb.size() < DEPTH);
      total++; if (bus.fifo_count !== 3'(sb.size())) $display("FAIL drain_count[%0d] got %0d exp %0d", i, bus.fifo_count, sb.size()); else passed++;
      e = sb.pop_front();
      total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== e.rd || bus.rf_wdata !== e.data)
        $display("FAIL drain_head[%0d] got %b/%0d/%h exp 1/%0d/%h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.rd, e.data); else passed++;
      if (bus.lu_valid && rdy_exp) begin e.rd = 5'd20; e.data = 32'hC0DE; sb.push_back(e); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    total++; if (bus.fifo_count !== 3'd0 || bus.rf_we !== 1'b0)
      $display("FAIL drain_empty got %0d/%b exp 0/0", bus.fifo_count, bus.rf_we); else passed++;
    next_cycle();
  endtask

  task automatic test_starve();
    ent_t e;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h99;
    e.rd = 5'd9; e.data = 32'h99; sb.push_back(e);
    next_cycle();
    bus.lu_valid = 1'b0;
    for (int k = 1; k <= STARVE_MAX; k++) begin
      @(negedge clk);
      total++; if (bus.pipe_stall !== 1'b0 || bus.rf_waddr !== 5'd2)
        $display("FAIL starve_wait[%0d] got %b/%0d exp 0/2", k, bus.pipe_stall, bus.rf_waddr); else passed++;
      next_cycle();
    end
    bus.wb_en = 1'b0; bus.wb_sys_en = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    total++; if (bus.pipe_stall !== 1'b1) $display("FAIL starve_stall got %b exp 1", bus.pipe_stall); else passed++;
    total++; if (bus.rf_we !== 1'b1 || bus.rf_sys_we !== 1'b0 || bus.rf_waddr !== e.rd || bus.rf_wdata !== e.data)
      $display("FAIL starve_drain got %b/%b/%0d/%h exp 1/0/%0d/%h", bus.rf_we, bus.rf_sys_we, bus.rf_waddr,
               bus.rf_wdata, e.rd, e.data); else passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++; if (bus.pipe_stall !== 1'b0 || bus.fifo_count !== 3'd0 || bus.proto_err !== 1'b0)
      $display("FAIL starve_after got %b/%0d/%b exp 0/0/0", bus.pipe_stall, bus.fifo_count, bus.proto_err); else passed++;
    next_cycle();
  endtask

  task automatic test_proto_err();
    ent_t e;
    queue_and_starve(5'd6, 32'h66);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'h2020;
    @(negedge clk);
    e = sb.pop_front();
    total++; if (bus.pipe_stall !== 1'b1 || bus.rf_waddr !== e.rd || bus.rf_wdata !== e.data)
      $display("FAIL perr_drain got %b/%0d/%h exp 1/%0d/%h", bus.pipe_stall, bus.rf_waddr, bus.rf_wdata, e.rd, e.data); else passed++;
    total++; if (bus.proto_err !== 1'b0) $display("FAIL perr_before got %b exp 0", bus.proto_err); else passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++; if (bus.proto_err !== 1'b1) $display("FAIL perr_set got %b exp 1", bus.proto_err); else passed++;
    repeat (3) next_cycle();
    @(negedge clk);
    total++; if (bus.proto_err !== 1'b1) $display("FAIL perr_sticky got %b exp 1", bus.proto_err); else passed++;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.proto_err !== 1'b0) $display("FAIL perr_clear got %b exp 0", bus.proto_err); else passed++;
    next_cycle();
  endtask

  task automatic test_pend_and_reset_drain();
    ent_t e;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2;
    for (int c = 0; c <= STARVE_MAX; c++) begin
      bus.lu_valid = (c < 2);
      bus.lu_rd    = (c == 0) ? 5'd7 : 5'd0;
      bus.lu_data  = 32'h77;
      if (c < 2) begin e.rd = bus.lu_rd; e.data = 32'h77; sb.push_back(e); end
      if (c == 2) begin
        bus.pend_q = 5'd7;
        @(negedge clk);
        total++; if (bus.pend_hit !== 1'b1) $display("FAIL pend_hit7 got %b exp 1", bus.pend_hit); else passed++;
        bus.pend_q = 5'd0; #1;
        total++; if (bus.pend_hit !== 1'b0) $display("FAIL pend_hit0 got %b exp 0", bus.pend_hit); else passed++;
        bus.pend_q = 5'd8; #1;
        total++; if (bus.pend_hit !== 1'b0) $display("FAIL pend_hit8 got %b exp 0", bus.pend_hit); else passed++;
      end
      next_cycle();
    end
    bus.wb_en = 1'b0;
    @(negedge clk);
    total++; if (bus.pipe_stall !== 1'b1) $display("FAIL rst_drain_stall got %b exp 1", bus.pipe_stall); else passed++;
    reset = 1'b1;
    #1;
    total++; if (bus.rf_we !== 1'b0) $display("FAIL rst_drain_we got %b exp 0", bus.rf_we); else passed++;
    next_cycle();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    total++; if (bus.fifo_count !== 3'd0 || bus.pipe_stall !== 1'b0 || bus.rf_we !== 1'b0)
      $display("FAIL rst_drain_after got %0d/%b/%b exp 0/0/0", bus.fifo_count, bus.pipe_stall, bus.rf_we); else passed++;
    total++; if (bus.pend_hit !== 1'b0) $display("FAIL rst_drain_pend got %b exp 0", bus.pend_hit); else passed++;
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_lu_path();
    test_fill_and_drain();
    test_starve();
    test_proto_err();
    test_pend_and_reset_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
